wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the ALU write-back stream and the load-return stream from data memory. It sits between execute/memory and the register file, and drives the registered write enable, address and data. It tracks destinations of loads still in flight in a busy scoreboard that decode uses for interlock. A one-entry hold register parks an ALU result that loses arbitration to a load return, so no result is ever dropped.

---
 rtl/wb_port_arbiter_pkg.sv | 7 +
 rtl/wb_hold_reg.sv | 47 ++++
 rtl/wb_port_arbiter.sv | 92 +++++++++
 tb/tb_wb_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths and opcodes for the write-back port arbiter.
package wb_port_arbiter_pkg;
  localparam int WB_XLEN = 32;
  localparam int WB_RA_W = 5;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/wb_hold_reg.sv
// wb_hold_reg: one-entry parking register for an ALU result that lost the write port.
module wb_hold_reg
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN = WB_XLEN,
  parameter int RA_W = WB_RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_wr,
  input  logic [RA_W-1:0] i_rd,
  input  logic [XLEN-1:0] i_data,
  output logic            o_full,
  output logic            o_wr,
  output logic [RA_W-1:0] o_rd,
  output logic [XLEN-1:0] o_data
);
  logic            full_d, full_q;
  logic            wr_d, wr_q;
  logic [RA_W-1:0] rd_d, rd_q;
  logic [XLEN-1:0] data_d, data_q;
  always_comb begin
    full_d = i_load ? 1'b1 : i_drain ? 1'b0 : full_q;
    wr_d   = i_load ? i_wr : wr_q;
    rd_d   = i_load ? i_rd : rd_q;
    data_d = i_load ? i_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end
  assign o_full = full_q;
  assign o_wr   = wr_q;
  assign o_rd   = rd_q;
  assign o_data = data_q;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between load returns and ALU results.
// Define WB_SCOREBOARD_EN to maintain the in-flight load busy map; otherwise it reads as 0.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN = WB_XLEN,
  parameter int RA_W = WB_RA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  input  logic                 i_alu_valid,
  output logic                 o_alu_ready,
  input  logic                 i_alu_wr,
  input  logic [RA_W-1:0]      i_alu_rd,
  input  logic [XLEN-1:0]      i_alu_data,
  input  logic                 i_ld_issue,
  input  logic [RA_W-1:0]      i_ld_issue_rd,
  input  logic                 i_ld_valid,
  input  logic [RA_W-1:0]      i_ld_rd,
  input  logic [XLEN-1:0]      i_ld_data,
  output logic                 o_rf_wr_en,
  output logic [RA_W-1:0]      o_rf_wr_addr,
  output logic [XLEN-1:0]      o_rf_wr_data,
  output logic [2**RA_W-1:0]   o_busy_map
);
  logic            alu_acc, park, drain;
  logic            hold_full, hold_wr;
  logic [RA_W-1:0] hold_rd;
  logic [XLEN-1:0] hold_data;
  logic            wr_en_d, wr_en_q;
  logic [RA_W-1:0] wr_addr_d, wr_addr_q;
  logic [XLEN-1:0] wr_data_d, wr_data_q;
  assign o_alu_ready = !halt && !hold_full;
  assign alu_acc     = i_alu_valid && o_alu_ready;
  assign park        = alu_acc && i_ld_valid;
  assign drain       = hold_full && !i_ld_valid;
  wb_hold_reg #(.XLEN(XLEN), .RA_W(RA_W)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_load (park),
    .i_drain(drain),
    .i_wr   (i_alu_wr),
    .i_rd   (i_alu_rd),
    .i_data (i_alu_data),
    .o_full (hold_full),
    .o_wr   (hold_wr),
    .o_rd   (hold_rd),
    .o_data (hold_data)
  );
  // Load return cannot stall, so it always wins; a parked result beats a fresh one.
  always_comb begin
    wr_en_d   = i_ld_valid ? (i_ld_rd != '0)
              : hold_full  ? (hold_wr && hold_rd != '0)
              : (alu_acc && i_alu_wr && i_alu_rd != '0);
    wr_addr_d = i_ld_valid ? i_ld_rd : hold_full ? hold_rd : alu_acc ? i_alu_rd : wr_addr_q;
    wr_data_d = i_ld_valid ? i_ld_data : hold_full ? hold_data : alu_acc ? i_alu_data : wr_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign o_rf_wr_en   = wr_en_q;
  assign o_rf_wr_addr = wr_addr_q;
  assign o_rf_wr_data = wr_data_q;
`ifdef WB_SCOREBOARD_EN
  localparam int NREG = 2**RA_W;
  logic [NREG-1:0] busy_d, busy_q, set_v, clr_v;
  // Set applied after clear so a same-cycle reissue keeps the bit; x0 is never busy.
  always_comb begin
    set_v  = i_ld_issue ? (NREG'(1) << i_ld_issue_rd) : '0;
    clr_v  = i_ld_valid ? (NREG'(1) << i_ld_rd) : '0;
    busy_d = ((busy_q & ~clr_v) | set_v) & ~NREG'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign o_busy_map = busy_q;
`else
  logic unused_ld_issue;
  assign unused_ld_issue = &{1'b0, i_ld_issue, i_ld_issue_rd};
  assign o_busy_map      = '0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scenario tasks with a queue of expected write-port results.
module tb_wb_port_arbiter;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, halt;
  logic        i_alu_valid, i_alu_wr, o_alu_ready;
  logic [4:0]  i_alu_rd, i_ld_issue_rd, i_ld_rd, o_rf_wr_addr;
  logic [31:0] i_alu_data, i_ld_data, o_rf_wr_data, o_busy_map;
  logic        i_ld_issue, i_ld_valid, o_rf_wr_en;
  int vectors = 0;
  int miss = 0;
  typedef struct {
    logic av, awr; logic [4:0] ard; logic [31:0] adata;
    logic lv; logic [4:0] lrd; logic [31:0] ldata;
    logic iss; logic [4:0] isrd; logic hlt, rdy;
    logic en; logic [4:0] addr; logic [31:0] data, busy;
  } stim_t;
  typedef struct {
    logic en; logic [4:0] addr; logic [31:0] data, busy;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  wb_port_arbiter dut (
    .clk(clk), .rst(rst), .halt(halt),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready), .i_alu_wr(i_alu_wr),
    .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_ld_issue(i_ld_issue), .i_ld_issue_rd(i_ld_issue_rd),
    .i_ld_valid(i_ld_valid), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
    .o_rf_wr_en(o_rf_wr_en), .o_rf_wr_addr(o_rf_wr_addr), .o_rf_wr_data(o_rf_wr_data),
    .o_busy_map(o_busy_map)
  );
  function automatic stim_t mk(int av, int awr, int ard, logic [31:0] adata,
                               int lv, int lrd, logic [31:0] ldata,
                               int iss, int isrd, int hlt, int rdy,
                               int en, int addr, logic [31:0] data, logic [31:0] busy);
    stim_t s;
    s.av = av[0]; s.awr = awr[0]; s.ard = ard[4:0]; s.adata = adata;
    s.lv = lv[0]; s.lrd = lrd[4:0]; s.ldata = ldata;
    s.iss = iss[0]; s.isrd = isrd[4:0]; s.hlt = hlt[0]; s.rdy = rdy[0];
    s.en = en[0]; s.addr = addr[4:0]; s.data = data;
    s.busy = SB ? busy : 32'h0;
    return s;
  endfunction
  task automatic apply(input stim_t s);
    i_alu_valid = s.av; i_alu_wr = s.awr; i_alu_rd = s.ard; i_alu_data = s.adata;
    i_ld_valid = s.lv; i_ld_rd = s.lrd; i_ld_data = s.ldata;
    i_ld_issue = s.iss; i_ld_issue_rd = s.isrd; halt = s.hlt;
    sb.push_back('{en: s.en, addr: s.addr, data: s.data, busy: s.busy});
  endtask
  task automatic test_reset();
    exp_t e;
    apply(mk(0,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0,0));
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if (o_rf_wr_en !== e.en || o_rf_wr_addr !== e.addr || o_rf_wr_data !== e.data || o_busy_map !== e.busy || o_alu_ready !== 1'b1) begin
      miss++;
      $display("FAIL reset_state: got en=%b addr=%0d data=%h busy=%h rdy=%b expected all zero, rdy=1", o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_busy_map, o_alu_ready);
    end
    rst = 1'b0;
    apply(mk(1,1,3,32'hA, 1,7,32'hB, 1,4,0, 1, 1,7,32'hB,32'h10));
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if (o_rf_wr_en !== e.en || o_rf_wr_addr !== e.addr || o_rf_wr_data !== e.data || o_busy_map !== e.busy || o_alu_ready !== 1'b0) begin
      miss++;
      $display("FAIL reset_prefill: got en=%b addr=%0d data=%h busy=%h rdy=%b expected en=%b addr=%0d data=%h busy=%h rdy=0", o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_busy_map, o_alu_ready, e.en, e.addr, e.data, e.busy);
    end
    apply(mk(0,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0,0));
    rst = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if (o_rf_wr_en !== e.en || o_rf_wr_addr !== e.addr || o_rf_wr_data !== e.data || o_busy_map !== e.busy || o_alu_ready !== 1'b1) begin
      miss++;
      $display("FAIL reset_midop: got en=%b addr=%0d data=%h busy=%h rdy=%b expected all zero, rdy=1", o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_busy_map, o_alu_ready);
    end
    rst = 1'b0;
    apply(mk(0,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0,0));
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if (o_rf_wr_en !== e.en || o_busy_map !== e.busy) begin
      miss++;
      $display("FAIL reset_hold_discard: got en=%b busy=%h expected en=%b busy=%h", o_rf_wr_en, o_busy_map, e.en, e.busy);
    end
  endtask
  task automatic test_plain_alu();
    stim_t s[$];
    exp_t e;
    s.push_back(mk(1,1,5,32'h1234, 0,0,0, 0,0,0, 1, 1,5,32'h1234,0));
    s.push_back(mk(1,1,20,32'h20, 0,0,0, 0,0,0, 1, 1,20,32'h20,0));
    s.push_back(mk(1,1,31,32'hFFFF_FFFF, 0,0,0, 0,0,0, 1, 1,31,32'hFFFF_FFFF,0));
    s.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0,0));
    foreach (s[i]) begin
      apply(s[i]); #1;
      vectors++;
      if (o_alu_ready !== s[i].rdy) begin
        miss++;
        $display("FAIL plain_alu step %0d ready: got %b expected %b", i, o_alu_ready, s[i].rdy);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if (o_rf_wr_en !== e.en || (e.en && (o_rf_wr_addr !== e.addr || o_rf_wr_data !== e.data)) || o_busy_map !== e.busy) begin
        miss++;
        $display("FAIL plain_alu step %0d write: got en=%b addr=%0d data=%h busy=%h expected en=%b addr=%0d data=%h busy=%h", i, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_busy_map, e.en, e.addr, e.data, e.busy);
      end
    end
  endtask
  task automatic test_collision();
    stim_t s[$];
    exp_t e;
    s.push_back(mk(1,1,3,32'hA, 1,7,32'hB, 0,0,0, 1, 1,7,32'hB,0));
    s.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 0, 1,3,32'hA,0));
    s.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0,0));
    foreach (s[i]) begin
      apply(s[i]); #1;
      vectors++;
      if (o_alu_ready !== s[i].rdy) begin
        miss++;
        $display("FAIL collision step %0d ready: got %b expected %b", i, o_alu_ready, s[i].rdy);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if (o_rf_wr_en !== e.en || (e.en && (o_rf_wr_addr !== e.addr || o_rf_wr_data !== e.data)) || o_busy_map !== e.busy) begin
        miss++;
        $display("FAIL collision step %0d write: got en=%b addr=%0d data=%h busy=%h expected en=%b addr=%0d data=%h busy=%h", i, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_busy_map, e.en, e.addr, e.data, e.busy);
      end
    end
  endtask
  task automatic test_back_to_back();
    stim_t s[$];
    exp_t e;
    s.push_back(mk(1,1,9,32'hC, 1,1,32'h11, 0,0,0, 1, 1,1,32'h11,0));
    s.push_back(mk(1,1,9,32'hC, 1,2,32'h22, 0,0,0, 0, 1,2,32'h22,0));
    s.push_back(mk(1,1,9,32'hC, 1,3,32'h33, 0,0,0, 0, 1,3,32'h33,0));
    s.push_back(mk(1,1,9,32'hC, 0,0,0, 0,0,0, 0, 1,9,32'hC,0));
    s.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0,0));
    foreach (s[i]) begin
      apply(s[i]); #1;
      vectors++;
      if (o_alu_ready !== s[i].rdy) begin
        miss++;
        $display("FAIL back_to_back step %0d ready: got %b expected %b", i, o_alu_ready, s[i].rdy);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if (o_rf_wr_en !== e.en || (e.en && (o_rf_wr_addr !== e.addr || o_rf_wr_data !== e.data)) || o_busy_map !== e.busy) begin
        miss++;
        $display("FAIL back_to_back step %0d write: got en=%b addr=%0d data=%h busy=%h expected en=%b addr=%0d data=%h busy=%h", i, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_busy_map, e.en, e.addr, e.data, e.busy);
      end
    end
  endtask
  task automatic test_scoreboard();
    stim_t s[$];
    exp_t e;
    s.push_back(mk(0,0,0,0, 0,0,0, 1,9,0, 1, 0,0,0,32'h200));
    s.push_back(mk(0,0,0,0, 1,9,32'h99, 1,9,0, 1, 1,9,32'h99,32'h200));
    s.push_back(mk(0,0,0,0, 1,9,32'h77, 0,0,0, 1, 1,9,32'h77,0));
    s.push_back(mk(0,0,0,0, 0,0,0, 1,0,0, 1, 0,0,0,0));
    s.push_back(mk(0,0,0,0, 0,0,0, 1,31,0, 1, 0,0,0,32'h8000_0000));
    s.push_back(mk(0,0,0,0, 0,0,0, 1,2,0, 1, 0,0,0,32'h8000_0004));
    s.push_back(mk(0,0,0,0, 1,31,32'h31, 0,0,0, 1, 1,31,32'h31,32'h4));
    s.push_back(mk(0,0,0,0, 1,2,32'h2, 0,0,0, 1, 1,2,32'h2,0));
    foreach (s[i]) begin
      apply(s[i]); #1;
      vectors++;
      if (o_alu_ready !== s[i].rdy) begin
        miss++;
        $display("FAIL scoreboard step %0d ready: got %b expected %b", i, o_alu_ready, s[i].rdy);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if (o_rf_wr_en !== e.en || (e.en && (o_rf_wr_addr !== e.addr || o_rf_wr_data !== e.data)) || o_busy_map !== e.busy) begin
        miss++;
        $display("FAIL scoreboard step %0d write: got en=%b addr=%0d data=%h busy=%h expected en=%b addr=%0d data=%h busy=%h", i, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_busy_map, e.en, e.addr, e.data, e.busy);
      end
    end
  endtask
  task automatic test_filter();
    stim_t s[$];
    exp_t e;
    s.push_back(mk(1,0,6,32'h5, 0,0,0, 0,0,0, 1, 0,0,0,0));
    s.push_back(mk(1,1,0,32'h6, 0,0,0, 0,0,0, 1, 0,0,0,0));
    s.push_back(mk(1,1,4,32'h7, 1,8,32'h88, 0,0,1, 0, 1,8,32'h88,0));
    s.push_back(mk(0,0,0,0, 1,0,32'h99, 0,0,1, 0, 0,0,0,0));
    s.push_back(mk(1,1,12,32'hC1, 1,13,32'hD1, 0,0,0, 1, 1,13,32'hD1,0));
    s.push_back(mk(0,0,0,0, 0,0,0, 0,0,1, 0, 1,12,32'hC1,0));
    s.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0,0));
    s.push_back(mk(1,0,14,32'hE1, 1,15,32'hF1, 0,0,0, 1, 1,15,32'hF1,0));
    s.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    foreach (s[i]) begin
      apply(s[i]); #1;
      vectors++;
      if (o_alu_ready !== s[i].rdy) begin
        miss++;
        $display("FAIL filter step %0d ready: got %b expected %b", i, o_alu_ready, s[i].rdy);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if (o_rf_wr_en !== e.en || (e.en && (o_rf_wr_addr !== e.addr || o_rf_wr_data !== e.data)) || o_busy_map !== e.busy) begin
        miss++;
        $display("FAIL filter step %0d write: got en=%b addr=%0d data=%h busy=%h expected en=%b addr=%0d data=%h busy=%h", i, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_busy_map, e.en, e.addr, e.data, e.busy);
      end
    end
  endtask
  initial begin
    rst = 1'b1; halt = 1'b0;
    i_alu_valid = 1'b0; i_alu_wr = 1'b0; i_alu_rd = '0; i_alu_data = '0;
    i_ld_issue = 1'b0; i_ld_issue_rd = '0; i_ld_valid = 1'b0; i_ld_rd = '0; i_ld_data = '0;
    test_reset();
    test_plain_alu();
    test_collision();
    test_back_to_back();
    test_scoreboard();
    test_filter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
